imgproc_job_sequencer: RTL and testbench
========================================

IMGPROC_JOB_SEQUENCER -- requirements
Module: imgproc_job_sequencer

Interface
REQ-001 Parameter ADDR_W, default 32: width of the source and destination address fields.
REQ-002 Parameter LEN_W, default 16: width of the pixel-count field.
REQ-003 Parameter DEPTH, default 4: job FIFO entries, power of 2, at least 2.
REQ-004 Parameter TIMEOUT_CYCLES, default 1024: watchdog limit in cycles.
REQ-005 ACLK  in  1  sole clock; all logic on the rising edge.
REQ-006 ARESETN  in  1  reset, synchronous and active-low.
REQ-007 job_valid/job_ready  in/out  1/1  job push handshake from the AXI4-Lite register block.
REQ-008 job_src, job_dst, job_len, job_op  in  ADDR_W/ADDR_W/LEN_W/2  job descriptor.
REQ-009 enable  in  1  when low, no new job is dequeued.
REQ-010 flush  in  1  one-cycle pulse that discards all queued (not running) jobs.
REQ-011 core_start  out  1  one-cycle launch pulse to the processing core.
REQ-012 core_src, core_dst, core_len, core_op  out  ADDR_W/ADDR_W/LEN_W/2  registered descriptor, stable from core_start until the job ends.
REQ-013 core_done, core_error  in  1/1  completion pulse; core_error is qualified by core_done.
REQ-014 idle  out  1  high when the FIFO is empty and the FSM is in IDLE.
REQ-015 irq, irq_clr  out/in  1/1  sticky interrupt and its clear.
REQ-016 jobs_done, jobs_err  out  16/16  completion and error counters.
REQ-017 fifo_level  out  clog2(DEPTH)+1  number of queued entries.

Function
REQ-018 job_ready SHALL equal !full && !flush; a push SHALL occur only when job_valid && job_ready at a clock edge.
REQ-019 A simultaneous push and pop SHALL leave fifo_level unchanged; at full, a push SHALL be refused even if a pop occurs in the same cycle.
REQ-020 The FSM states SHALL be IDLE, LAUNCH and RUN.
REQ-021 IDLE->LAUNCH SHALL occur when the FIFO is not empty, enable=1 and flush=0; the head entry is popped and latched onto core_*.
REQ-022 LAUNCH SHALL last exactly one cycle with core_start=1, then move to RUN.
REQ-023 A job pushed into an empty FIFO at edge N while in IDLE with enable=1 SHALL have core_start high during the cycle after edge N+1.
REQ-024 In LAUNCH or RUN, core_done=1 SHALL return the FSM to IDLE and increment jobs_done if core_error=0, otherwise jobs_err.
REQ-025 A dequeued job with job_len=0 SHALL NOT assert core_start, SHALL increment jobs_err, and SHALL leave the FSM in IDLE.
REQ-026 Counters SHALL saturate at 0xFFFF.
REQ-027 irq SHALL be set on any error, or on a successful completion that leaves the FIFO empty; it SHALL be cleared by irq_clr, and set SHALL win when set and irq_clr occur in the same cycle.
REQ-028 flush SHALL zero fifo_level on the next edge without aborting a job in LAUNCH or RUN.
REQ-029 Deasserting enable SHALL NOT affect a running job.

Reset
REQ-030 ARESETN=0 at an edge SHALL force IDLE, empty the FIFO, and set core_start=0, core_*=0, jobs_done=0, jobs_err=0, irq=0, idle=1 and job_ready=0 while reset is held.
REQ-031 A reset during RUN SHALL abandon the job without counting it.

Configuration
REQ-032 With IMGPROC_SEQ_TIMEOUT_EN defined, a watchdog SHALL count the cycles spent in RUN; on reaching TIMEOUT_CYCLES without core_done it SHALL increment jobs_err, set irq and return to IDLE, and a later stray core_done SHALL be ignored.
REQ-033 Without IMGPROC_SEQ_TIMEOUT_EN, no watchdog logic SHALL exist and RUN SHALL wait indefinitely.

Verification
REQ-034 Push src=0x1000, dst=0x2000, len=64, op=1 into an empty FIFO -> core_start is pulsed once 2 cycles later with the descriptor; core_done -> jobs_done=1, irq=1, idle=1.
REQ-035 Push 5 jobs with enable=0 and DEPTH=4 -> job_ready drops after the 4th push and fifo_level=4; set enable=1 -> 5 core_start pulses in FIFO order.
REQ-036 Push a job with len=0 -> no core_start, jobs_err=1, irq=1; irq_clr -> irq=0.
REQ-037 Queue 3 jobs, let job 1 run, then pulse flush -> fifo_level=0; job 1 completes, jobs_done=1, and no further core_start occurs.
REQ-038 With IMGPROC_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16, withhold core_done -> after 16 cycles in RUN, jobs_err=1 and the FSM is in IDLE; a late core_done leaves the counters unchanged.
REQ-039 Assert ARESETN=0 mid-RUN for 1 cycle -> all outputs are at their reset values on the next cycle and no counter increments.

Source files
------------

// File: rtl/imgproc_job_sequencer.sv
// Image-processing job sequencer: queues descriptors pushed by the register block and
// launches them one at a time on the processing core. Optional watchdog: IMGPROC_SEQ_TIMEOUT_EN.
module imgproc_job_sequencer #(
  parameter int ADDR_W         = 32,
  parameter int LEN_W          = 16,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  input  logic                       job_valid,
  output logic                       job_ready,
  input  logic [ADDR_W-1:0]          job_src,
  input  logic [ADDR_W-1:0]          job_dst,
  input  logic [LEN_W-1:0]           job_len,
  input  logic [1:0]                 job_op,
  input  logic                       enable,
  input  logic                       flush,
  output logic                       core_start,
  output logic [ADDR_W-1:0]          core_src,
  output logic [ADDR_W-1:0]          core_dst,
  output logic [LEN_W-1:0]           core_len,
  output logic [1:0]                 core_op,
  input  logic                       core_done,
  input  logic                       core_error,
  output logic                       idle,
  output logic                       irq,
  input  logic                       irq_clr,
  output logic [15:0]                jobs_done,
  output logic [15:0]                jobs_err,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [1:0]                 state_dbg
);

  // Handshake: a job is taken on a rising edge where job_valid && job_ready;
  // job_valid may not depend on job_ready, and the descriptor must be held
  // stable while job_valid is high and the job has not yet been taken.

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int DESC_W = 2 * ADDR_W + LEN_W + 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  state_t state;

  logic [DESC_W-1:0] mem [DEPTH];
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;
  logic [PTR_W:0]    level;
  logic [PTR_W:0]    level_next;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  logic [DESC_W-1:0] head;
  logic [ADDR_W-1:0] head_src;
  logic [ADDR_W-1:0] head_dst;
  logic [LEN_W-1:0]  head_len;
  logic [1:0]        head_op;
  logic              head_zero;

  logic              busy;
  logic              done_ok;
  logic              done_err;
  logic              zero_len;
  logic              timeout_hit;
  logic              err_evt;
  logic              irq_set;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level     = wr_ptr - rd_ptr;
  assign full      = (level == (PTR_W + 1)'(DEPTH));
  assign empty     = (level == '0);
  assign job_ready = ARESETN && !full && !flush;
  assign push      = job_valid && job_ready;
  assign pop       = (state == ST_IDLE) && !empty && enable && !flush;

  assign head      = mem[rd_ptr[PTR_W-1:0]];
  assign head_src  = head[DESC_W-1 -: ADDR_W];
  assign head_dst  = head[DESC_W-ADDR_W-1 -: ADDR_W];
  assign head_len  = head[LEN_W+1:2];
  assign head_op   = head[1:0];
  assign head_zero = (head_len == '0);

  always_comb begin
    level_next = level;
    if (flush)
      level_next = '0;
    else if (push && !pop)
      level_next = level + 1'b1;
    else if (!push && pop)
      level_next = level - 1'b1;
  end

  always_ff @(posedge ACLK) begin
    if (push)
      mem[wr_ptr[PTR_W-1:0]] <= {job_src, job_dst, job_len, job_op};
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      // Flush only drops queued entries; the running job already left the FIFO.
      if (flush)
        rd_ptr <= wr_ptr;
      else if (pop)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

`ifdef IMGPROC_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;

  // A done arriving on the final watchdog cycle still counts as a normal completion.
  assign timeout_hit = (state == ST_RUN) && !core_done &&
                       (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge ACLK) begin
    if (!ARESETN || state != ST_RUN)
      wd_cnt <= '0;
    else
      wd_cnt <= wd_cnt + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign busy     = (state == ST_LAUNCH) || (state == ST_RUN);
  assign done_ok  = busy && core_done && !core_error;
  assign done_err = busy && core_done && core_error;
  assign zero_len = pop && head_zero;
  assign err_evt  = done_err || zero_len || timeout_hit;
  assign irq_set  = err_evt || (done_ok && level_next == '0);

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state      <= ST_IDLE;
      core_start <= 1'b0;
      core_src   <= '0;
      core_dst   <= '0;
      core_len   <= '0;
      core_op    <= '0;
      jobs_done  <= '0;
      jobs_err   <= '0;
      irq        <= 1'b0;
    end else begin
      core_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Zero-length jobs are consumed and counted as errors without launching.
          if (pop && !head_zero) begin
            core_src   <= head_src;
            core_dst   <= head_dst;
            core_len   <= head_len;
            core_op    <= head_op;
            core_start <= 1'b1;
            state      <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          if (core_done)
            state <= ST_IDLE;
          else
            state <= ST_RUN;
        end
        ST_RUN: begin
          if (core_done || timeout_hit)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (done_ok && jobs_done != 16'hFFFF)
        jobs_done <= jobs_done + 16'd1;
      if (err_evt && jobs_err != 16'hFFFF)
        jobs_err <= jobs_err + 16'd1;

      if (irq_set)
        irq <= 1'b1;
      else if (irq_clr)
        irq <= 1'b0;
    end
  end

  assign idle       = empty && (state == ST_IDLE);
  assign fifo_level = level;
  assign state_dbg  = state;

endmodule

// File: tb/tb_imgproc_job_sequencer.sv
// Directed bench for imgproc_job_sequencer: hand-computed expectations, launch scoreboard,
// and the watchdog scenario when IMGPROC_SEQ_TIMEOUT_EN is defined.
module tb_imgproc_job_sequencer;
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 16;
  localparam int DEPTH  = 4;
  localparam int DW     = 2 * ADDR_W + LEN_W + 2;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;

  logic              ACLK = 1'b0;
  logic              ARESETN = 1'b0;
  logic              job_valid = 1'b0;
  logic              job_ready;
  logic [ADDR_W-1:0] job_src = '0;
  logic [ADDR_W-1:0] job_dst = '0;
  logic [LEN_W-1:0]  job_len = '0;
  logic [1:0]        job_op = '0;
  logic              enable = 1'b0;
  logic              flush = 1'b0;
  logic              core_start;
  logic [ADDR_W-1:0] core_src;
  logic [ADDR_W-1:0] core_dst;
  logic [LEN_W-1:0]  core_len;
  logic [1:0]        core_op;
  logic              core_done = 1'b0;
  logic              core_error = 1'b0;
  logic              idle;
  logic              irq;
  logic              irq_clr = 1'b0;
  logic [15:0]       jobs_done;
  logic [15:0]       jobs_err;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [1:0]        state_dbg;

  int checks = 0;
  int errors = 0;
  int n_start = 0;
  logic [DW-1:0] exp_q[$];

  imgproc_job_sequencer #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DEPTH(DEPTH), .TIMEOUT_CYCLES(16)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_src(job_src), .job_dst(job_dst), .job_len(job_len), .job_op(job_op),
    .enable(enable), .flush(flush),
    .core_start(core_start), .core_src(core_src), .core_dst(core_dst),
    .core_len(core_len), .core_op(core_op),
    .core_done(core_done), .core_error(core_error),
    .idle(idle), .irq(irq), .irq_clr(irq_clr),
    .jobs_done(jobs_done), .jobs_err(jobs_err),
    .fifo_level(fifo_level), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench time limit");
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every launch must match the oldest expected descriptor
  always @(negedge ACLK) begin
    if (core_start === 1'b1) begin
      n_start++;
      check("start_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0)
        check("start_desc", {core_src, core_dst, core_len, core_op}, exp_q.pop_front());
    end
  end

  // driver tasks (all called just after a falling edge)
  task automatic push(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                      input logic [1:0] o, input bit exp_start);
    int n;
    n = 0;
    job_src = s; job_dst = d; job_len = l; job_op = o;
    job_valid = 1'b1;
    #1;
    while (!job_ready && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    check("push_ready_budget", n < 50, 1);
    @(negedge ACLK);
    job_valid = 1'b0;
    if (exp_start) exp_q.push_back({s, d, l, o});
  endtask

  task automatic wait_state(input logic [1:0] target);
    int n;
    n = 0;
    while (state_dbg !== target && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    check("wait_state_budget", state_dbg, target);
  endtask

  task automatic pulse_done(input logic err, input logic clr);
    core_done = 1'b1; core_error = err; irq_clr = clr;
    @(negedge ACLK);
    core_done = 1'b0; core_error = 1'b0; irq_clr = 1'b0;
  endtask

  task automatic clear_irq();
    irq_clr = 1'b1;
    @(negedge ACLK);
    irq_clr = 1'b0;
    check("irq_cleared", irq, 0);
  endtask

  initial begin
    // reset values while reset is held
    repeat (3) @(negedge ACLK);
    check("rst_idle", idle, 1);
    check("rst_job_ready", job_ready, 0);
    check("rst_core_start", core_start, 0);
    check("rst_core_src", core_src, 0);
    check("rst_jobs_done", jobs_done, 0);
    check("rst_jobs_err", jobs_err, 0);
    check("rst_irq", irq, 0);
    check("rst_level", fifo_level, 0);
    check("rst_state", state_dbg, S_IDLE);
    ARESETN = 1'b1;
    enable = 1'b1;
    @(negedge ACLK);
    check("job_ready_after_rst", job_ready, 1);

    // single job: launch two edges after the push
    push(32'h1000, 32'h2000, 16'd64, 2'd1, 1);
    check("t1_no_start_yet", core_start, 0);
    @(negedge ACLK);
    check("t1_start", core_start, 1);
    @(negedge ACLK);
    check("t1_start_once", core_start, 0);
    check("t1_state_run", state_dbg, S_RUN);
    check("t1_len_stable", core_len, 64);
    pulse_done(1'b0, 1'b0);
    check("t1_jobs_done", jobs_done, 1);
    check("t1_irq", irq, 1);
    check("t1_idle", idle, 1);
    clear_irq();

    // zero-length job
    push(32'h3000, 32'h4000, 16'd0, 2'd2, 0);
    @(negedge ACLK);
    check("t2_jobs_err", jobs_err, 1);
    check("t2_irq", irq, 1);
    check("t2_state", state_dbg, S_IDLE);
    check("t2_idle", idle, 1);
    check("t2_no_start", n_start, 1);
    clear_irq();

    // fill FIFO with enable low, then drain in order
    enable = 1'b0;
    for (int i = 0; i < 4; i++)
      push(32'h10000 + 32'(i * 256), 32'h20000 + 32'(i * 256), 16'(16 + i), 2'(i), 1);
    check("t3_full_not_ready", job_ready, 0);
    check("t3_level4", fifo_level, 4);
    check("t3_not_idle", idle, 0);
    check("t3_no_launch", n_start, 1);
    job_src = 32'h10400; job_dst = 32'h20400; job_len = 16'd20; job_op = 2'd0;
    job_valid = 1'b1;
    exp_q.push_back({32'h10400, 32'h20400, 16'd20, 2'd0});
    enable = 1'b1;
    @(negedge ACLK);
    check("t3_ready_after_pop", job_ready, 1);
    check("t3_first_start", core_start, 1);
    check("t3_level3", fifo_level, 3);
    @(negedge ACLK);
    job_valid = 1'b0;
    check("t3_level_refill", fifo_level, 4);
    check("t3_run", state_dbg, S_RUN);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) wait_state(S_RUN);
      pulse_done(1'b0, 1'b0);
      check("t3_irq_only_last", irq, (i == 4) ? 1 : 0);
    end
    check("t3_jobs_done", jobs_done, 6);
    check("t3_starts", n_start, 6);
    check("t3_level0", fifo_level, 0);
    check("t3_idle", idle, 1);
    clear_irq();

    // error completion with irq_clr in the same cycle: set wins
    push(32'h5000, 32'h6000, 16'd8, 2'd3, 1);
    wait_state(S_RUN);
    pulse_done(1'b1, 1'b1);
    check("t4_irq_set_wins", irq, 1);
    check("t4_jobs_err", jobs_err, 2);
    check("t4_jobs_done", jobs_done, 6);
    clear_irq();

    // flush discards queued jobs but not the running one
    enable = 1'b0;
    push(32'hA100, 32'hB100, 16'd5, 2'd1, 1);
    push(32'hA200, 32'hB200, 16'd6, 2'd2, 0);
    push(32'hA300, 32'hB300, 16'd7, 2'd3, 0);
    check("t5_level3", fifo_level, 3);
    enable = 1'b1;
    wait_state(S_RUN);
    check("t5_level2", fifo_level, 2);
    flush = 1'b1;
    #1;
    check("t5_flush_not_ready", job_ready, 0);
    @(negedge ACLK);
    flush = 1'b0;
    check("t5_level_flushed", fifo_level, 0);
    check("t5_still_run", state_dbg, S_RUN);
    pulse_done(1'b0, 1'b0);
    check("t5_jobs_done", jobs_done, 7);
    check("t5_irq", irq, 1);
    repeat (6) @(negedge ACLK);
    check("t5_stay_idle", state_dbg, S_IDLE);
    check("t5_no_more_start", n_start, 8);
    clear_irq();

`ifdef IMGPROC_SEQ_TIMEOUT_EN
    // watchdog fires on the 16th edge spent in RUN
    push(32'h7000, 32'h8000, 16'd4, 2'd0, 1);
    wait_state(S_RUN);
    repeat (15) @(negedge ACLK);
    check("t6_still_run", state_dbg, S_RUN);
    @(negedge ACLK);
    check("t6_timeout_idle", state_dbg, S_IDLE);
    check("t6_jobs_err", jobs_err, 3);
    check("t6_irq", irq, 1);
    pulse_done(1'b0, 1'b0);
    check("t6_stray_done", jobs_done, 7);
    check("t6_stray_err", jobs_err, 3);
    clear_irq();
`endif

    // reset in the middle of a running job
    push(32'h9000, 32'hA000, 16'd2, 2'd1, 1);
    wait_state(S_RUN);
    ARESETN = 1'b0;
    @(negedge ACLK);
    check("t7_core_start", core_start, 0);
    check("t7_core_src", core_src, 0);
    check("t7_core_len", core_len, 0);
    check("t7_jobs_done", jobs_done, 0);
    check("t7_jobs_err", jobs_err, 0);
    check("t7_irq", irq, 0);
    check("t7_idle", idle, 1);
    check("t7_job_ready", job_ready, 0);
    check("t7_level", fifo_level, 0);
    check("t7_state", state_dbg, S_IDLE);
    ARESETN = 1'b1;
    pulse_done(1'b0, 1'b0);
    check("t7_no_count_done", jobs_done, 0);
    check("t7_no_count_err", jobs_err, 0);
    check("t7_state_after", state_dbg, S_IDLE);

    check("exp_q_drained", exp_q.size(), 0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
